window_gen: RTL and testbench

//  Parametrised K x K sliding-window generator for raster-order pixel streams.
//  - Stores K-1 previous image lines; on every accepted pixel, emits the full K x K

---
 rtl/window_gen_pkg.sv | 11 +
 rtl/window_gen_line_mem.sv | 26 ++
 rtl/window_gen.sv | 124 ++++++++++++
 tb/tb_window_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_gen_pkg.sv
// Shared defaults for the K x K sliding-window generator and its line store.
package window_gen_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_IMG_WIDTH   = 8;
    localparam int DEF_IMG_HEIGHT  = 6;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int K_MIN           = 2;
    localparam int K_MAX           = 7;

endpackage

// File: rtl/window_gen_line_mem.sv
// One image line of pixels: asynchronous read of the old word, write of the new word at the same address.
module line_mem
    import window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IMG_WIDTH,
    localparam int AW        = $clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_gen.sv
// K x K sliding-window generator for raster pixel streams; emits only fully populated windows.
module window_gen
    import window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int K          = DEF_KERNEL_SIZE,
    localparam int CW        = $clog2(IMG_WIDTH),
    localparam int RW        = $clog2(IMG_HEIGHT)
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] pixel_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*K*DATA_WIDTH-1:0]    win_flat,
    output logic [RW-1:0]                out_row,
    output logic [CW-1:0]                out_col,
    output logic                         frame_last
);

    logic                         w_acc;
    logic                         w_qual;
    logic                         w_col_wrap;
    logic                         w_row_wrap;
    logic [CW-1:0]                r_col;
    logic [RW-1:0]                r_row;
    logic [DATA_WIDTH-1:0]        w_line_rd  [K-1];
    logic [DATA_WIDTH-1:0]        w_line_wr  [K-1];
    logic [DATA_WIDTH-1:0]        w_new_col  [K];
    logic [DATA_WIDTH-1:0]        r_win      [K][K-1];
    logic [DATA_WIDTH-1:0]        w_win_next [K][K];
    logic [K*K*DATA_WIDTH-1:0]    w_win_flat;

    // Handshake: a transfer happens on a side when valid and ready are both high at the
    // rising edge; the single output register frees up in the same cycle it is drained.
    assign in_ready   = ~out_valid | out_ready;
    assign w_acc      = in_valid & in_ready;
    assign w_col_wrap = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_wrap = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_qual     = w_acc && (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));

    // Line k holds image row r-(K-1)+k at column c; each write pushes the column up one line.
    for (genvar k = 0; k < K - 1; k++) begin : g_line
        if (k == K - 2) begin : g_top
            assign w_line_wr[k] = pixel_in;
        end else begin : g_mid
            assign w_line_wr[k] = w_line_rd[k+1];
        end

        line_mem #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH)
        ) u_line (
            .clk     (clk),
            .i_we    (w_acc),
            .i_addr  (r_col),
            .i_wdata (w_line_wr[k]),
            .o_rdata (w_line_rd[k])
        );

        assign w_new_col[k] = w_line_rd[k];
    end

    assign w_new_col[K-1] = pixel_in;

    // r_win keeps the K-1 most recent columns; the incoming column completes the window.
    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            if (j < K - 1) begin : g_old
                assign w_win_next[i][j] = r_win[i][j];
            end else begin : g_new
                assign w_win_next[i][j] = w_new_col[i];
            end
            assign w_win_flat[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] = w_win_next[i][j];
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    r_win[i][j] <= w_win_next[i][j+1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            win_flat   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_last <= 1'b0;
        end else if (w_qual) begin
            out_valid  <= 1'b1;
            win_flat   <= w_win_flat;
            out_row    <= r_row - RW'(K - 1);
            out_col    <= r_col - CW'(K - 1);
            frame_last <= w_row_wrap && w_col_wrap;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen: a K=3 instance (16-bit) and a K=5 instance (8-bit signed).
module tb_window_gen;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int K3  = 3;
  localparam int DW3 = 16;
  localparam int K5  = 5;
  localparam int DW5 = 8;
  localparam int WB3 = K3 * K3 * DW3;
  localparam int WB5 = K5 * K5 * DW5;
  localparam int EW3 = WB3 + 7;
  localparam int EW5 = WB5 + 7;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  in_valid3, in_ready3, out_valid3, out_ready3, last3;
  logic signed [DW3-1:0] pixel3;
  logic [WB3-1:0]        win3;
  logic [2:0]            row3, col3;

  logic                  in_valid5, in_ready5, out_valid5, out_ready5, last5;
  logic signed [DW5-1:0] pixel5;
  logic [WB5-1:0]        win5;
  logic [2:0]            row5, col5;

  window_gen #(.DATA_WIDTH(DW3), .IMG_WIDTH(W), .IMG_HEIGHT(H), .K(K3)) u_dut3 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .pixel_in(pixel3), .out_valid(out_valid3), .out_ready(out_ready3),
    .win_flat(win3), .out_row(row3), .out_col(col3), .frame_last(last3)
  );

  window_gen #(.DATA_WIDTH(DW5), .IMG_WIDTH(W), .IMG_HEIGHT(H), .K(K5)) u_dut5 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .pixel_in(pixel5), .out_valid(out_valid5), .out_ready(out_ready5),
    .win_flat(win5), .out_row(row5), .out_col(col5), .frame_last(last5)
  );

  // scoreboard state
  int             n_checks = 0;
  int             n_pass   = 0;
  logic [EW3-1:0] exp_q[$];
  logic [EW5-1:0] exp5_q[$];
  logic [EW3-1:0] e3;
  logic [EW5-1:0] e5;
  int             n_rx3, n_rx5, first_cyc3, acc18_cyc;
  bit             first_seen3;
  logic [WB3-1:0] first_win3, last_win3, f2_win3;
  logic [2:0]     last_row3, last_col3;
  logic           last_flag3;
  logic [WB5-1:0] first_win5, last_win5;
  logic           last_flag5;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [WB3-1:0] win3_model(input int orow, input int ocol, input int off);
    logic [WB3-1:0] w;
    w = '0;
    for (int i = 0; i < K3; i++)
      for (int j = 0; j < K3; j++)
        w[(i*K3+j)*DW3 +: DW3] = 16'((orow + i) * 16 + ocol + j + off);
    return w;
  endfunction

  function automatic logic [WB5-1:0] win5_model(input int ocol);
    logic [WB5-1:0] w;
    w = '0;
    for (int i = 0; i < K5; i++)
      for (int j = 0; j < K5; j++)
        w[(i*K5+j)*DW5 +: DW5] = 8'(-128 + ocol + j);
    return w;
  endfunction

  function automatic logic [WB3-1:0] pack3x3(input int v[9]);
    logic [WB3-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW3 +: DW3] = 16'(v[k]);
    return w;
  endfunction

  task automatic enqueue3(input int off);
    for (int orow = 0; orow <= H - K3; orow++)
      for (int ocol = 0; ocol <= W - K3; ocol++)
        exp_q.push_back({(orow == H - K3 && ocol == W - K3), 3'(orow), 3'(ocol),
                         win3_model(orow, ocol, off)});
  endtask

  task automatic reset_rx();
    n_rx3 = 0;
    first_seen3 = 1'b0;
  endtask

  // monitors: a window is taken on the edge following a negedge with valid & ready
  always @(negedge clk) begin
    if (rst_n && out_valid3 && out_ready3) begin
      if (exp_q.size() == 0) begin
        check("unexpected_win3", 1, 0);
      end else begin
        e3 = exp_q.pop_front();
        check("win3", win3, e3[WB3-1:0]);
        check("col3", col3, e3[WB3 +: 3]);
        check("row3", row3, e3[WB3+3 +: 3]);
        check("last3", last3, e3[WB3+6]);
      end
      if (!first_seen3) begin
        first_seen3 = 1'b1;
        first_win3  = win3;
        first_cyc3  = cyc;
      end
      if (n_rx3 == 24) f2_win3 = win3;
      last_win3  = win3;
      last_row3  = row3;
      last_col3  = col3;
      last_flag3 = last3;
      n_rx3++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid5 && out_ready5) begin
      if (exp5_q.size() == 0) begin
        check("unexpected_win5", 1, 0);
      end else begin
        e5 = exp5_q.pop_front();
        check("win5", win5, e5[WB5-1:0]);
        check("col5", col5, e5[WB5 +: 3]);
        check("row5", row5, e5[WB5+3 +: 3]);
        check("last5", last5, e5[WB5+6]);
      end
      if (n_rx5 == 0) first_win5 = win5;
      last_win5  = win5;
      last_flag5 = last5;
      n_rx5++;
    end
  end

  // driver tasks: called and returning at posedge+1
  task automatic push3(input logic [DW3-1:0] v, input bit gaps, output int acc_at);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        in_valid3 = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid3 = 1'b1;
    pixel3    = v;
    guard     = 0;
    forever begin
      @(negedge clk);
      if (in_ready3) begin
        @(posedge clk);
        break;
      end
      @(posedge clk);
      guard++;
      if (guard > 50) begin
        check("push3_timeout", 0, 1);
        break;
      end
    end
    #1;
    acc_at    = cyc;
    in_valid3 = 1'b0;
  endtask

  task automatic push5(input logic [DW5-1:0] v);
    int guard;
    in_valid5 = 1'b1;
    pixel5    = v;
    guard     = 0;
    forever begin
      @(negedge clk);
      if (in_ready5) begin
        @(posedge clk);
        break;
      end
      @(posedge clk);
      guard++;
      if (guard > 50) begin
        check("push5_timeout", 0, 1);
        break;
      end
    end
    #1;
    in_valid5 = 1'b0;
  endtask

  task automatic stream3(input int off, input bit gaps, input int n_pix);
    int t;
    for (int n = 0; n < n_pix; n++) begin
      push3(16'((n / W) * 16 + (n % W) + off), gaps, t);
      if (n == (K3 - 1) * W + (K3 - 1)) acc18_cyc = t;
    end
  endtask

  task automatic drain3(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle_valid"}, out_valid3, 0);
  endtask

  task automatic stall3();
    logic [WB3-1:0] snap_win;
    logic [2:0]     snap_row, snap_col;
    int             g;
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (!out_valid3 && g < 200);
    check("stall_saw_valid", out_valid3, 1);
    out_ready3 = 1'b0;
    snap_win = win3;
    snap_row = row3;
    snap_col = col3;
    check("stall_first_win", snap_win, win3_model(0, 0, 0));
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", in_ready3, 0);
      check("stall_valid", out_valid3, 1);
      check("stall_win", win3, snap_win);
      check("stall_row", row3, snap_row);
      check("stall_col", col3, snap_col);
    end
    @(posedge clk); #1;
    out_ready3 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int lst[9];
    int g;
    in_valid3 = 1'b0; pixel3 = '0; out_ready3 = 1'b1;
    in_valid5 = 1'b0; pixel5 = '0; out_ready5 = 1'b1;
    n_rx5 = 0;
    reset_rx();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid3", out_valid3, 0);
    check("rst_win3", win3, 0);
    check("rst_row3", row3, 0);
    check("rst_col3", col3, 0);
    check("rst_last3", last3, 0);
    check("rst_in_ready3", in_ready3, 1);
    check("rst_valid5", out_valid5, 0);
    check("rst_win5", win5, 0);
    rst_n = 1'b1;

    // scenario 1: continuous stream, consumer always ready
    reset_rx();
    enqueue3(0);
    stream3(0, 1'b0, W * H);
    drain3("s1");
    check("s1_count", n_rx3, 24);
    lst = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    check("s1_first_win", first_win3, pack3x3(lst));
    check("s1_latency", first_cyc3 - acc18_cyc, 0);
    check("s1_last_flag", last_flag3, 1);
    check("s1_last_row", last_row3, 3);
    check("s1_last_col", last_col3, 5);
    check("s1_last_centre", last_win3[64 +: 16], 70);

    // scenario 2: consumer stalls 5 cycles on the first window
    reset_rx();
    enqueue3(0);
    fork
      stream3(0, 1'b0, W * H);
      stall3();
    join
    drain3("s2");
    check("s2_count", n_rx3, 24);

    // scenario 3: ~50% input duty
    reset_rx();
    enqueue3(0);
    stream3(0, 1'b1, W * H);
    drain3("s3");
    check("s3_count", n_rx3, 24);
    check("s3_first_win", first_win3, pack3x3(lst));

    // scenario 4: two frames back to back
    reset_rx();
    enqueue3(0);
    enqueue3(100);
    stream3(0, 1'b0, W * H);
    stream3(100, 1'b0, W * H);
    drain3("s4");
    check("s4_count", n_rx3, 48);
    lst = '{100, 101, 102, 116, 117, 118, 132, 133, 134};
    check("s4_f2_first_win", f2_win3, pack3x3(lst));
    check("s4_last_flag", last_flag3, 1);

    // scenario 5: reset after 30 pixels, then restart the frame
    reset_rx();
    for (int ocol = 0; ocol <= W - K3; ocol++)
      exp_q.push_back({1'b0, 3'(0), 3'(ocol), win3_model(0, ocol, 0)});
    for (int ocol = 0; ocol < 3; ocol++)
      exp_q.push_back({1'b0, 3'(1), 3'(ocol), win3_model(1, ocol, 0)});
    stream3(0, 1'b0, 30);
    check("s5_pre_valid", out_valid3, 1);
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", out_valid3, 0);
    check("s5_rst_win", win3, 0);
    check("s5_rst_row", row3, 0);
    check("s5_rst_col", col3, 0);
    check("s5_pre_consumed", exp_q.size(), 0);
    check("s5_pre_count", n_rx3, 9);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_rx();
    enqueue3(0);
    stream3(0, 1'b0, W * H);
    drain3("s5");
    check("s5_count", n_rx3, 24);
    lst = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    check("s5_first_win", first_win3, pack3x3(lst));
    check("s5_latency", first_cyc3 - acc18_cyc, 0);

    // scenario 6: K=5, signed 8-bit pixels -128+c
    for (int orow = 0; orow <= H - K5; orow++)
      for (int ocol = 0; ocol <= W - K5; ocol++)
        exp5_q.push_back({(orow == H - K5 && ocol == W - K5), 3'(orow), 3'(ocol), win5_model(ocol)});
    for (int n = 0; n < W * H; n++) push5(8'(-128 + (n % W)));
    g = 0;
    while (exp5_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("s6_drained", exp5_q.size(), 0);
    check("s6_count", n_rx5, 8);
    check("s6_last_flag", last_flag5, 1);
    check("s6_first_e00", first_win5[0 +: 8], 8'h80);
    check("s6_first_e44", first_win5[24*8 +: 8], 8'h84);
    check("s6_last_e00", last_win5[0 +: 8], 8'h83);
    check("s6_last_e44", last_win5[24*8 +: 8], 8'h87);
    check("s6_idle_valid", out_valid5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
